// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner: 2-flop synchronizer plus stable-count debouncer
// per channel, with registered level and one-cycle rise/fall pulses.
module switch_debounce #(
  parameter int unsigned NUM_SWITCHES    = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [NUM_SWITCHES-1:0] i_switch,
  output logic [NUM_SWITCHES-1:0] o_switch,
  output logic [NUM_SWITCHES-1:0] o_rise,
  output logic [NUM_SWITCHES-1:0] o_fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SWITCHES-1:0] r_sync1;
  logic [NUM_SWITCHES-1:0] r_sync2;
  logic [NUM_SWITCHES-1:0] r_switch;
  logic [NUM_SWITCHES-1:0] r_rise;
  logic [NUM_SWITCHES-1:0] r_fall;
  logic [CW-1:0]           r_count [NUM_SWITCHES];

  logic [NUM_SWITCHES-1:0] w_switch_nxt;
  logic [NUM_SWITCHES-1:0] w_rise_nxt;
  logic [NUM_SWITCHES-1:0] w_fall_nxt;
  logic [CW-1:0]           w_count_nxt [NUM_SWITCHES];

  // State registers; synchronizers run regardless of enable.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_switch <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        r_count[n] <= '0;
      end
    end else begin
      r_sync1  <= i_switch;
      r_sync2  <= r_sync1;
      r_switch <= w_switch_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        r_count[n] <= w_count_nxt[n];
      end
    end
  end

  // Qualification: a mismatch must persist DEBOUNCE_CYCLES enabled cycles; the
  // counter clears on acceptance so it can never wrap.
  always_comb begin
    w_switch_nxt = r_switch;
    w_rise_nxt   = '0;
    w_fall_nxt   = '0;
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      w_count_nxt[n] = r_count[n];
    end
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      if (!i_enable || (r_sync2[n] == r_switch[n])) begin
        w_count_nxt[n] = '0;
      end else if (r_count[n] == LAST_COUNT) begin
        w_switch_nxt[n] = r_sync2[n];
        w_rise_nxt[n]   = r_sync2[n];
        w_fall_nxt[n]   = ~r_sync2[n];
        w_count_nxt[n]  = '0;
      end else begin
        w_count_nxt[n] = r_count[n] + CW'(1);
      end
    end
  end

  assign o_switch = r_switch;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce against a windowed
// reference model of the debounce rules.
module tb_switch_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_enable;
  logic [1:0] i_switch;
  logic [1:0] o_switch;
  logic [1:0] o_rise;
  logic [1:0] o_fall;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [1:0] q_raw [$];
  logic [1:0] q_s2  [$];
  bit         q_en  [$];
  logic [1:0] m_out, m_rise, m_fall;

  switch_debounce #(.NUM_SWITCHES(2), .DEBOUNCE_CYCLES(D)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_enable (i_enable),
    .i_switch (i_switch),
    .o_switch (o_switch),
    .o_rise   (o_rise),
    .o_fall   (o_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_raw.delete();
    q_s2.delete();
    q_en.delete();
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  // Output at an edge flips when the last D edges were all enabled and the
  // twice-delayed raw input differed from the current output at each of them.
  task automatic model_step(input logic [1:0] sw, input logic en);
    logic [1:0] s2;
    int sz;
    bit ok;
    s2 = (q_raw.size() >= 2) ? q_raw[q_raw.size()-2] : 2'b00;
    q_s2.push_back(s2);
    q_en.push_back(en);
    q_raw.push_back(sw);
    m_rise = '0;
    m_fall = '0;
    sz = q_s2.size();
    for (int n = 0; n < 2; n++) begin
      ok = (sz >= D);
      for (int j = 0; j < D && ok; j++) begin
        if (!q_en[sz-1-j] || (q_s2[sz-1-j][n] == m_out[n])) ok = 0;
      end
      if (ok) begin
        m_out[n]  = ~m_out[n];
        m_rise[n] = m_out[n];
        m_fall[n] = ~m_out[n];
      end
    end
  endtask

  task automatic tick(input logic [1:0] sw, input logic en);
    i_switch = sw;
    i_enable = en;
    @(posedge clk);
    model_step(sw, en);
    #1;
    chk("o_switch", 32'(o_switch), 32'(m_out));
    chk("o_rise",   32'(o_rise),   32'(m_rise));
    chk("o_fall",   32'(o_fall),   32'(m_fall));
    @(negedge clk);
  endtask

  // Count edges from the first edge that samples sw until o_switch == want.
  task automatic run_until(input string tag, input logic [1:0] sw, input logic en,
                           input logic [1:0] want, input int exp_ticks);
    int  n = 0;
    bit  hit = 0;
    while (!hit && n < 30) begin
      tick(sw, en);
      n++;
      if (o_switch === want) hit = 1;
    end
    chk(tag, hit ? 32'(n) : 32'hffff_ffff, 32'(exp_ticks));
  endtask

  initial begin
    logic [1:0] sw;
    logic       en;
    rst_n    = 1'b0;
    i_switch = 2'b00;
    i_enable = 1'b0;
    model_reset();
    #1;
    chk("reset_sw",   32'(o_switch), 32'h0);
    chk("reset_rise", 32'(o_rise),   32'h0);
    chk("reset_fall", 32'(o_fall),   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean rise on switch_1: visible D+1 edges after the sampling edge.
    run_until("rise_latency", 2'b01, 1'b1, 2'b01, D + 2);
    chk("rise_pulse", 32'(o_rise), 32'h1);
    for (int i = 0; i < 8; i++) tick(2'b01, 1'b1);
    for (int i = 0; i < 12; i++) tick(2'b00, 1'b1);
    chk("dropped", 32'(o_switch), 32'h0);

    // Bounce every 2 cycles; no activity, then latency from the last transition.
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2 == 0) ? 2'b01 : 2'b00, 1'b1);
    chk("bounce_quiet", 32'(o_switch), 32'h0);
    run_until("bounce_latency", 2'b01, 1'b1, 2'b01, D + 2);

    // Simultaneous release of both channels.
    for (int i = 0; i < 12; i++) tick(2'b11, 1'b1);
    chk("both_high", 32'(o_switch), 32'h3);
    run_until("release_latency", 2'b00, 1'b1, 2'b00, D + 2);
    chk("release_fall", 32'(o_fall), 32'h3);
    tick(2'b00, 1'b1);
    chk("release_fall_once", 32'(o_fall), 32'h0);

    // Enable low freezes everything; qualification restarts on re-enable.
    for (int i = 0; i < 50; i++) tick(2'b10, 1'b0);
    chk("enable_hold", 32'(o_switch), 32'h0);
    run_until("enable_latency", 2'b10, 1'b1, 2'b10, D);

    // Asynchronous reset two cycles into a count.
    for (int i = 0; i < 4; i++) tick(2'b11, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sw",   32'(o_switch), 32'h0);
    chk("async_rst_rise", 32'(o_rise),   32'h0);
    chk("async_rst_fall", 32'(o_fall),   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_until("reset_latency", 2'b11, 1'b1, 2'b11, D + 2);

    // Random bouncing and enable gaps against the model.
    sw = 2'b11;
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) sw = sw ^ 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick(sw, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
